// File: rtl/pc_update_unit.sv
// pc_update_unit: registered next-PC selection for the Y86-64 SEQ core.
// It adds a stall enable, a RUN/HALTED/ERROR status machine, a
// retired-instruction counter and a shadow return-address stack that flags
// any ret whose target differs from the address pushed by its matching call.
module pc_update_unit #(
  parameter int            N         = 64,
  parameter logic [N-1:0]  RESET_PC  = '0,
  parameter int            RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [3:0]                   icode,
  input  logic                         cnd,
  input  logic [N-1:0]                 valC,
  input  logic [N-1:0]                 valM,
  input  logic [N-1:0]                 valP,
  output logic [N-1:0]                 PC,
  output logic [1:0]                   stat,
  output logic [31:0]                  retired,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_mismatch
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0] CNT_ONE   = 1;
  localparam logic [CW-1:0] CNT_FULL  = RAS_DEPTH[CW-1:0];

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_MAXV = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_ERROR  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pc_q, pc_d;
  logic [31:0]     retired_q, retired_d;
  logic [AW-1:0]   top_q, top_d;        // next free slot; top entry is top_q-1
  logic [CW-1:0]   count_q, count_d;
  logic            mismatch_q, mismatch_d;
  logic [N-1:0]    ras_mem [RAS_DEPTH];

  logic            accept;
  logic            do_push;
  logic            do_pop;
  logic [N-1:0]    top_entry;

  assign accept    = (state_q == ST_RUN) && en;
  assign do_push   = accept && (icode == I_CALL);
  assign do_pop    = accept && (icode == I_RET) && (count_q != '0);
  // Small shadow stack: the top entry is read combinationally so the compare
  // lands in the same cycle as the ret it belongs to.
  assign top_entry = ras_mem[top_q - PTR_ONE];

  // State register (status FSM)
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: halt and invalid codes are absorbing until reset
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (icode == I_HALT)     state_d = ST_HALTED;
      else if (icode > I_MAXV) state_d = ST_ERROR;
    end
  end

  // Output decode of the status state
  always_comb begin
    stat = 2'b00;
    case (state_q)
      ST_HALTED: stat = 2'b01;
      ST_ERROR:  stat = 2'b10;
      default:   stat = 2'b00;
    endcase
  end

  // Next PC, retired count, stack pointers and mismatch flag
  always_comb begin
    pc_d       = pc_q;
    retired_d  = retired_q;
    top_d      = top_q;
    count_d    = count_q;
    mismatch_d = 1'b0;
    if (accept) begin
      if (icode <= I_MAXV) retired_d = retired_q + 32'd1;
      if (icode == I_JXX)                          pc_d = cnd ? valC : valP;
      else if (icode == I_CALL)                    pc_d = valC;
      else if (icode == I_RET)                     pc_d = valM;
      else if (icode != I_HALT && icode <= I_MAXV) pc_d = valP;
      if (do_push) begin
        // When full the write slot is the oldest entry, so it is overwritten
        top_d = top_q + PTR_ONE;
        if (count_q != CNT_FULL) count_d = count_q + CNT_ONE;
      end
      if (do_pop) begin
        top_d      = top_q - PTR_ONE;
        count_d    = count_q - CNT_ONE;
        mismatch_d = (top_entry != valM);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      retired_q  <= '0;
      top_q      <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      top_q      <= top_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Shadow stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[top_q] <= valP;
  end

  assign PC           = pc_q;
  assign retired      = retired_q;
  assign ras_count    = count_q;
  assign ras_mismatch = mismatch_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed and random stimulus for pc_update_unit,
// checked against a behavioural model (queue-based return stack).
module tb_pc_update_unit;

  localparam int          N         = 64;
  localparam logic [63:0] RST_PC    = 64'h100;
  localparam int          RAS_DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset, en, cnd;
  logic [3:0]    icode;
  logic [63:0]   valC, valM, valP;
  logic [63:0]   PC;
  logic [1:0]    stat;
  logic [31:0]   retired;
  logic [3:0]    ras_count;
  logic          ras_mismatch;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] m_pc;
  int          m_state;     // 0 run, 1 halted, 2 error
  logic [31:0] m_ret;
  logic [63:0] m_stack[$];
  bit          m_mis;

  pc_update_unit #(.N(N), .RESET_PC(RST_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .icode(icode), .cnd(cnd),
    .valC(valC), .valM(valM), .valP(valP), .PC(PC), .stat(stat),
    .retired(retired), .ras_count(ras_count), .ras_mismatch(ras_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input logic [3:0] ic, input bit c,
                       input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
    logic [63:0] t;
    if (r) begin
      m_pc = RST_PC; m_state = 0; m_ret = 0; m_stack.delete(); m_mis = 0;
    end else if (e && m_state == 0) begin
      m_mis = 0;
      if (ic <= 4'hB) m_ret = m_ret + 1;
      if (ic == 4'h0) m_state = 1;
      else if (ic >= 4'hC) m_state = 2;
      else if (ic == 4'h7) m_pc = c ? vc : vp;
      else if (ic == 4'h8) begin
        m_pc = vc;
        m_stack.push_back(vp);
        if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
      end else if (ic == 4'h9) begin
        m_pc = vm;
        if (m_stack.size() > 0) begin
          t = m_stack.pop_back();
          m_mis = (t != vm);
        end
      end else m_pc = vp;
    end else m_mis = 0;
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] ic, input bit c,
                      input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
    reset = r; en = e; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
    @(posedge clk);
    #1;
    model(r, e, ic, c, vc, vm, vp);
    check("pc", PC, m_pc);
    check("stat", {62'd0, stat}, 64'(m_state));
    check("retired", {32'd0, retired}, {32'd0, m_ret});
    check("ras_count", {60'd0, ras_count}, 64'(m_stack.size()));
    check("ras_mismatch", {63'd0, ras_mismatch}, {63'd0, m_mis});
    $display("step rst=%0d en=%0d icode=%h cnd=%0d PC=%h stat=%0d retired=%0d ras=%0d mis=%0d",
             r, e, ic, c, PC, stat, retired, ras_count, ras_mismatch);
  endtask

  initial begin
    logic [3:0]  ic;
    logic [63:0] vm;
    m_pc = RST_PC; m_state = 0; m_ret = 0; m_mis = 0;

    // Reset and first nop
    step(1, 0, 4'h1, 0, 0, 0, 0);
    check("reset_pc", PC, 64'h100);
    step(0, 1, 4'h1, 0, 0, 0, 64'h102);
    check("nop_pc", PC, 64'h102);
    check("nop_retired", {32'd0, retired}, 64'd1);

    // jXX taken / not taken, then a 3-edge stall with changing inputs
    step(0, 1, 4'h7, 1, 64'h40, 0, 64'h19);
    check("jxx_taken", PC, 64'h40);
    step(0, 1, 4'h7, 0, 64'h40, 0, 64'h19);
    check("jxx_not_taken", PC, 64'h19);
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'(4'h7 + i), 1, 64'h500 + 64'(i), 64'h600, 64'h700);
    check("stall_pc", PC, 64'h19);

    // call/ret matched and mismatched
    step(0, 1, 4'h8, 0, 64'h200, 0, 64'h30);
    check("call_cnt", {60'd0, ras_count}, 64'd1);
    step(0, 1, 4'h9, 0, 0, 64'h30, 0);
    check("ret_ok_mis", {63'd0, ras_mismatch}, 64'd0);
    step(0, 1, 4'h8, 0, 64'h200, 0, 64'h30);
    step(0, 1, 4'h9, 0, 0, 64'h34, 0);
    check("ret_bad_pc", PC, 64'h34);
    check("ret_bad_mis", {63'd0, ras_mismatch}, 64'd1);
    step(0, 1, 4'h1, 0, 0, 0, 64'h36);
    check("mis_pulse_end", {63'd0, ras_mismatch}, 64'd0);

    // Overflow: 9 calls, 8 matching rets, one ret on empty stack
    for (int i = 1; i <= 9; i++) step(0, 1, 4'h8, 0, 64'h1000, 0, 64'(i));
    check("ras_full", {60'd0, ras_count}, 64'd8);
    for (int i = 9; i >= 2; i--) step(0, 1, 4'h9, 0, 0, 64'(i), 0);
    step(0, 1, 4'h9, 0, 0, 64'h77, 0);
    check("ras_empty_ret", {60'd0, ras_count}, 64'd0);
    check("ras_empty_mis", {63'd0, ras_mismatch}, 64'd0);

    // Halt at retired=5, then frozen, then reset
    step(1, 0, 4'h1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 4'h1, 0, 0, 0, 64'h110 + 64'(i));
    step(0, 1, 4'h0, 0, 0, 0, 64'h999);
    check("halt_stat", {62'd0, stat}, 64'd1);
    check("halt_retired", {32'd0, retired}, 64'd6);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h1, 0, 0, 0, 64'h888);
    check("halt_pc_hold", PC, 64'h114);
    step(1, 1, 4'h1, 0, 0, 0, 64'h888);
    check("halt_reset_stat", {62'd0, stat}, 64'd0);

    // Invalid icode
    step(0, 1, 4'h1, 0, 0, 0, 64'h120);
    step(0, 1, 4'hC, 0, 64'h5, 64'h6, 64'h7);
    check("ins_stat", {62'd0, stat}, 64'd2);
    check("ins_retired", {32'd0, retired}, 64'd1);
    step(0, 1, 4'h2, 0, 0, 0, 64'h140);
    step(1, 0, 4'h0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ic = 4'($urandom_range(1, 11));
      if ($urandom_range(0, 39) == 0) ic = 4'h0;
      if ($urandom_range(0, 39) == 0) ic = 4'($urandom_range(12, 15));
      if ($urandom_range(0, 3) == 0) ic = 4'h8;
      if ($urandom_range(0, 3) == 0) ic = 4'h9;
      vm = {$urandom, $urandom};
      if (m_stack.size() > 0 && $urandom_range(0, 1) == 1) vm = m_stack[$];
      step(($urandom_range(0, 29) == 0) || (m_state != 0 && $urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) != 0), ic, 1'($urandom),
           {$urandom, $urandom}, vm, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Parametrised sequential PC-update stage for the Y86-64 SEQ core. It registers the next program counter from `icode`, `cnd`, `valC`, `valM` and `valP`, and adds a stall enable, a synchronous reset vector, and a HALT/INS status state machine. A retired-instruction counter and a shadow return-address stack flag any `ret` whose target differs from the address pushed by its matching `call`.

## Interface
Parameters:
- `N`, 64: address/data width.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 8: shadow stack entries; a power of two, ≥2.

Ports:
- `clk`  in  1: clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; dominates all other inputs.
- `en`  in  1: advance enable; 0 freezes all state.
- `icode`  in  4: instruction code of the current instruction.
- `cnd`  in  1: condition result for jXX.
- `valC`  in  N: constant word, used as the jump/call target.
- `valM`  in  N: memory read value, used as the ret target.
- `valP`  in  N: fall-through address.
- `PC`  out  N: registered program counter.
- `stat`  out  2: 00 AOK, 01 HLT, 10 INS.
- `retired`  out  32: count of accepted instructions.
- `ras_count`  out  log2(RAS_DEPTH)+1: current shadow stack occupancy.
- `ras_mismatch`  out  1: one-cycle pulse when a ret target mismatches.

## Operation
- States: RUN (stat 00), HALTED (stat 01), ERROR (stat 10). HALTED and ERROR are absorbing; only `reset` leaves them.
- An instruction is accepted when the state is RUN and `en`=1 at a rising edge.
- Next-PC selection on acceptance:
  - icode 7 (jXX): `valC` if `cnd`=1, else `valP`.
  - icode 8 (call): `valC`.
  - icode 9 (ret): `valM`.
  - icode 1–6, A, B: `valP`.
  - icode 0 (halt): PC holds; state goes to HALTED.
  - icode ≥ 0xC: PC holds; state goes to ERROR; `retired` does not increment.
- `retired` increments by 1 for each accepted valid icode (0–0xB), halt included. It wraps from 2^32−1 to 0.
- Shadow stack (circular buffer plus occupancy count):
  - call pushes `valP`.
  - If the stack is full, the push overwrites the oldest entry and `ras_count` stays at `RAS_DEPTH`.
  - ret with `ras_count`>0 pops the top and compares it to `valM`. A difference makes `ras_mismatch`=1 for the next cycle only. The PC still takes `valM`; the flag is advisory.
  - ret with an empty stack: no pop, no compare, no flag.
- `en`=0 or a non-RUN state: PC, stack, counter and state all hold, and `ras_mismatch` reads 0.
- Arithmetic: selection only, no address adds. PC width is exactly N bits; no alignment check.

## Timing
- Reset values on the edge where `reset`=1:
  - PC = `RESET_PC`, stat = 00, `retired` = 0.
  - `ras_count` = 0, `ras_mismatch` = 0, stack contents don't-care.
- Reset during a stall or a HALTED/ERROR state behaves identically.
- Latency: inputs sampled at edge k appear on PC, stat, `retired`, `ras_count` and `ras_mismatch` right after edge k. Inputs for the next instruction must be valid before edge k+1.
- All outputs come directly from registers; there are no combinational input-to-output paths.
- `ras_mismatch` is high for exactly the cycle following the offending ret.
- Halt and invalid instructions take effect in the same cycle they are accepted. A later `en` pulse changes nothing.

## Test plan
- Reset with `RESET_PC`=0x100, then icode 1, `valP`=0x102, `en`=1 for one edge → PC=0x102, stat=00, `retired`=1.
- jXX with `valC`=0x40, `valP`=0x19: once with `cnd`=1 → PC=0x40; once with `cnd`=0 → PC=0x19. Then `en`=0 for 3 edges with changing inputs → PC, `retired` and `ras_count` unchanged.
- call (`valC`=0x200, `valP`=0x30), then ret with `valM`=0x30 → PC=0x30, `ras_count` 1→0, no mismatch. Repeat with `valM`=0x34 → PC=0x34 and `ras_mismatch`=1 for one cycle.
- With `RAS_DEPTH`=8: 9 calls with `valP`=1..9 → `ras_count`=8. Then 8 rets with `valM`=9..2 → no mismatch. A 9th ret → no compare, `ras_count`=0.
- halt at `retired`=5 → stat=01, `retired`=6, PC held. Further edges with icode 1 change nothing. Assert `reset` → PC=`RESET_PC`, stat=00, `retired`=0.
- icode 0xC → stat=10, PC held, `retired` unchanged. Preload `retired` near 2^32−1 by running accepted nops → the counter wraps to 0.
